// File: rtl/fft_peak_analyzer.sv
// Peak-bin finder for one 16-bin complex FFT frame: scans |X[k]|^2 one bin per cycle
// behind a single-frame hold buffer, reporting the lowest index of the maximum.
module fft_peak_analyzer #(
    parameter int NBINS = 16,
    parameter int DW    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fft_valid,
    input  logic [NBINS*2*DW-1:0]   fft_d,
    output logic                    done,
    output logic [3:0]              freq,
    output logic [2*DW-1:0]         peak_mag,
    output logic                    busy,
    output logic                    overflow
);
    localparam int         BW   = 2 * DW;
    localparam logic [3:0] LAST = 4'(NBINS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                  r_state, w_next_state;
    logic [NBINS*BW-1:0]     r_hold, r_work;
    logic                    r_hold_full;
    logic [3:0]              r_idx, r_max_idx;
    logic [BW-1:0]           r_max;
    logic                    r_done, r_busy, r_overflow;
    logic [3:0]              r_freq;
    logic [BW-1:0]           r_peak;

    logic                    w_xfer, w_last, w_hold_full_next, w_take;
    logic signed [DW-1:0]    w_re, w_im;
    logic signed [BW-1:0]    w_re2, w_im2;
    logic [BW-1:0]           w_mag;

    assign w_re  = r_work[int'(r_idx)*BW + DW +: DW];
    assign w_im  = r_work[int'(r_idx)*BW +: DW];
    assign w_re2 = w_re * w_re;
    assign w_im2 = w_im * w_im;
    assign w_mag = $unsigned(w_re2) + $unsigned(w_im2);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (r_hold_full) w_next_state = SCAN;
            SCAN: if (r_idx == LAST && !r_hold_full) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_last = (r_state == SCAN) && (r_idx == LAST);
        w_xfer = r_hold_full && ((r_state == IDLE) || w_last);
        // A transfer out frees the hold on the same edge, so a new frame is never lost then.
        w_take = fft_valid && (!r_hold_full || w_xfer);
        w_hold_full_next = fft_valid ? 1'b1 : (w_xfer ? 1'b0 : r_hold_full);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold      <= '0;
            r_work      <= '0;
            r_hold_full <= 1'b0;
            r_idx       <= '0;
            r_max       <= '0;
            r_max_idx   <= '0;
            r_done      <= 1'b0;
            r_freq      <= '0;
            r_peak      <= '0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_hold_full <= w_hold_full_next;
            if (w_take) r_hold <= fft_d;
            if (fft_valid && !w_take) r_overflow <= 1'b1;

            if (w_xfer) begin
                r_work <= r_hold;
                r_idx  <= '0;
            end else if (r_state == SCAN) begin
                r_idx  <= r_idx + 4'd1;
            end

            if (r_state == SCAN && (r_idx == '0 || w_mag > r_max)) begin
                r_max     <= w_mag;
                r_max_idx <= r_idx;
            end

            r_done <= w_last;
            if (w_last) begin
                if (w_mag > r_max) begin
                    r_freq <= r_idx;
                    r_peak <= w_mag;
                end else begin
                    r_freq <= r_max_idx;
                    r_peak <= r_max;
                end
            end

            r_busy <= w_hold_full_next || (w_next_state == SCAN);
        end
    end

    assign done     = r_done;
    assign freq     = r_freq;
    assign peak_mag = r_peak;
    assign busy     = r_busy;
    assign overflow = r_overflow;
endmodule
